// File: rtl/spi_master_rw.sv
// spi_master_rw: SPI master for register read/write transactions.
// One command word per transaction, sent MSB-first. The MSB of the command
// selects write (1) or read (0). On a read, the trailing READ_WIDTH bit slots
// drive mosi low and capture miso instead.
// Frame: LEAD (cs low, sclk idle), SHIFT (2*CMD_WIDTH half-periods),
// TRAIL (sclk idle, cs low), GAP (cs high), then IDLE.
module spi_master_rw #(
  parameter int CMD_WIDTH  = 12,
  parameter int READ_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  parameter int NUM_CS     = 1,
  parameter int CS_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [CMD_WIDTH-1:0]  cmd_in,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  output logic                  sclk,
  output logic [NUM_CS-1:0]     cs,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  read_vld,
  output logic [READ_WIDTH-1:0] read_data
);

  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int HALF_W = $clog2(2 * CMD_WIDTH);
  localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [HALF_W-1:0]    HALF_LAST = HALF_W'(2 * CMD_WIDTH - 1);
  // Keeps the address/opcode bits of a read; clears the data-phase slots.
  localparam logic [CMD_WIDTH-1:0] READ_MASK =
    ~((CMD_WIDTH'(1) << READ_WIDTH) - CMD_WIDTH'(1));

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q;
  logic [HALF_W-1:0]       half_q, half_new;
  logic [CMD_WIDTH-1:0]    tx_sr, load;
  logic [READ_WIDTH-1:0]   rx_sr;
  logic [CS_W-1:0]         cs_q;
  logic                    is_rd;
  logic                    accept, div_last, edge_now, leading, sample, launch;

  assign cmd_rdy  = (state_q == IDLE);
  assign div_last = (div_q == DIV_LAST);
  assign load     = cmd_in[CMD_WIDTH-1] ? cmd_in : (cmd_in & READ_MASK);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus SCLK edge decode. Each SCLK edge falls on a half-period
  // boundary: even half index = leading edge, odd = trailing edge.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    edge_now = 1'b0;
    half_new = (state_q == LEAD) ? '0 : half_q + HALF_W'(1);
    case (state_q)
      IDLE:  if (cmd_vld) begin
               state_d = LEAD;
               accept  = 1'b1;
             end
      LEAD:  if (div_last) begin
               state_d  = SHIFT;
               edge_now = 1'b1;
             end
      SHIFT: if (div_last) begin
               if (half_q == HALF_LAST) state_d = TRAIL;
               else                     edge_now = 1'b1;
             end
      TRAIL: if (div_last) state_d = GAP;
      GAP:   if (div_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    leading = ~half_new[0];
    sample  = edge_now && (leading != CPHA);
    launch  = edge_now && (leading == CPHA);
  end

  // Half-period divider and half-period index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      half_q <= '0;
    end else begin
      if (state_d != state_q || div_last) div_q <= '0;
      else if (state_q != IDLE)           div_q <= div_q + DIV_W'(1);
      if (accept)        half_q <= '0;
      else if (edge_now) half_q <= half_new;
    end
  end

  // Serial datapath: sclk, mosi launch, miso capture, read result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk      <= CPOL;
      mosi      <= 1'b0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      cs_q      <= '0;
      is_rd     <= 1'b0;
      read_vld  <= 1'b0;
      read_data <= '0;
    end else begin
      read_vld <= 1'b0;
      if (edge_now) sclk <= CPOL ^ leading;
      if (accept) begin
        cs_q  <= cs_sel;
        is_rd <= ~cmd_in[CMD_WIDTH-1];
        // CPHA=0 needs the first bit on the wire before the first leading edge.
        if (!CPHA) begin
          mosi  <= load[CMD_WIDTH-1];
          tx_sr <= load << 1;
        end else begin
          mosi  <= 1'b0;
          tx_sr <= load;
        end
      end else if (launch) begin
        mosi  <= tx_sr[CMD_WIDTH-1];
        tx_sr <= tx_sr << 1;
      end else if (state_q == SHIFT && state_d == TRAIL) begin
        mosi <= 1'b0;
      end
      // Every bit slot is sampled; only the trailing READ_WIDTH survive.
      if (sample) rx_sr <= (rx_sr << 1) | READ_WIDTH'(miso);
      if (state_q == TRAIL && state_d == GAP && is_rd) begin
        read_data <= rx_sr;
        read_vld  <= 1'b1;
      end
    end
  end

  // Chip selects: only the latched in-range index goes low during the frame.
  always_comb begin
    cs = '1;
    if (state_q == LEAD || state_q == SHIFT || state_q == TRAIL)
      for (int i = 0; i < NUM_CS; i++)
        if (cs_q == CS_W'(i)) cs[i] = 1'b0;
  end

endmodule

// File: tb/tb_spi_master_rw.sv
// Bench for spi_master_rw: three instances (mode 0; CPOL=1/CPHA=1;
// four chip selects) driven one at a time through a shared slave model.
module tb_spi_master_rw;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [11:0] cmd_in = '0;
  logic [2:0]  cs_sel = '0;
  logic [2:0]  vld = '0;
  logic        miso = 1'b0;

  logic       rdy0, rdy1, rdy2, sclk0, sclk1, sclk2, mosi0, mosi1, mosi2;
  logic       rv0, rv1, rv2;
  logic [7:0] rd0, rd1, rd2;
  logic [0:0] cs0, cs1;
  logic [3:0] cs2;

  spi_master_rw u0 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cs_sel(cs_sel[0:0]),
    .cmd_vld(vld[0]), .cmd_rdy(rdy0), .sclk(sclk0), .cs(cs0), .mosi(mosi0),
    .miso(miso), .read_vld(rv0), .read_data(rd0));

  spi_master_rw #(.CPOL(1'b1), .CPHA(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cs_sel(cs_sel[0:0]),
    .cmd_vld(vld[1]), .cmd_rdy(rdy1), .sclk(sclk1), .cs(cs1), .mosi(mosi1),
    .miso(miso), .read_vld(rv1), .read_data(rd1));

  spi_master_rw #(.NUM_CS(4), .CS_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .cmd_in(cmd_in), .cs_sel(cs_sel),
    .cmd_vld(vld[2]), .cmd_rdy(rdy2), .sclk(sclk2), .cs(cs2), .mosi(mosi2),
    .miso(miso), .read_vld(rv2), .read_data(rd2));

  // View of the instance under test.
  int         cur = 0;
  logic       sclk_m, mosi_m, rdy_m, rv_m, cs_low_m;
  logic [7:0] rd_m;
  logic [3:0] cs_pat;
  always_comb begin
    case (cur)
      0:       begin sclk_m = sclk0; mosi_m = mosi0; rdy_m = rdy0; rv_m = rv0;
                     rd_m = rd0; cs_pat = {3'b111, cs0}; end
      1:       begin sclk_m = sclk1; mosi_m = mosi1; rdy_m = rdy1; rv_m = rv1;
                     rd_m = rd1; cs_pat = {3'b111, cs1}; end
      default: begin sclk_m = sclk2; mosi_m = mosi2; rdy_m = rdy2; rv_m = rv2;
                     rd_m = rd2; cs_pat = cs2; end
    endcase
    cs_low_m = ~&cs_pat;
  end

  // Slave model: loads resp on cs fall, presents MSB first, and on each
  // rising sclk (the sampling edge in both tested modes) records mosi and
  // moves to the next miso bit.
  logic [11:0] resp = '0, resp_sr = '0, cap = '0;
  logic        cs_prev = 1'b0, sclk_prev = 1'b0;
  int          clr_cnt = 0, clr_seen = 0;
  always @(cs_low_m or sclk_m or clr_cnt) begin
    if (clr_cnt != clr_seen) begin
      clr_seen = clr_cnt;
      cap = '0;
    end
    if (cs_low_m && !cs_prev) begin
      resp_sr = resp;
      miso = resp_sr[11];
      cap = '0;
    end else if (cs_low_m && sclk_m && !sclk_prev) begin
      cap = {cap[10:0], mosi_m};
      resp_sr = resp_sr << 1;
      miso = resp_sr[11];
    end
    cs_prev = cs_low_m;
    sclk_prev = sclk_m;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One transaction on instance d; counts from the accept edge until cmd_rdy
  // is seen again at a falling clk edge.
  task automatic run_txn(input int d, input logic [11:0] cmd, input logic [2:0] sel,
                         input logic [11:0] rsp, output int lat, output int low_n,
                         output int rv_n, output logic [3:0] pat);
    int k;
    cur = d; resp = rsp; clr_cnt++;
    low_n = 0; rv_n = 0; pat = 4'b1111; k = 0;
    @(negedge clk);
    cmd_in = cmd; cs_sel = sel; vld[d] = 1'b1;
    do begin
      @(negedge clk);
      if (k == 0) vld[d] = 1'b0;
      k++;
      if (cs_low_m) begin low_n++; pat = cs_pat; end
      if (rv_m) rv_n++;
    end while (!rdy_m && k < 500);
    if (k >= 500) chk("txn timeout", 32'(k), 32'd0);
    lat = k - 1;
  endtask

  typedef struct {
    int          d;
    logic [11:0] cmd;
    logic [2:0]  sel;
    logic [11:0] rsp;
    logic [11:0] mosi;
    int          cs_low;
    int          rv;
    logic [7:0]  rdata;
    logic [3:0]  pat;
  } vec_t;
  vec_t tv[8];

  initial begin
    int lat, low_n, rv_n, k, phase, rdy_k, cs_hi, end_k;
    logic [3:0]  pat;
    logic [11:0] cap1;
    logic        rdy_after, prev_low;

    // 12-bit frames: cs low (2*12+2)*4 = 104 cycles, idle again 27*4 = 108.
    tv[0] = '{0, 12'hA5C, 3'd0, 12'h000, 12'hA5C, 104, 0, 8'h00, 4'b1110};
    tv[1] = '{0, 12'h300, 3'd0, 12'h096, 12'h300, 104, 1, 8'h96, 4'b1110};
    tv[2] = '{0, 12'h8FF, 3'd0, 12'hFFF, 12'h8FF, 104, 0, 8'h96, 4'b1110};
    tv[3] = '{1, 12'h300, 3'd0, 12'h096, 12'h300, 104, 1, 8'h96, 4'b1110};
    tv[4] = '{1, 12'h0AA, 3'd0, 12'h0C3, 12'h000, 104, 1, 8'hC3, 4'b1110};
    tv[5] = '{2, 12'hA5C, 3'd2, 12'h000, 12'hA5C, 104, 0, 8'h00, 4'b1011};
    // Out of range: frame still runs, but no cs means the slave never clocks.
    tv[6] = '{2, 12'hA5C, 3'd7, 12'h000, 12'h000, 0,   0, 8'h00, 4'b1111};
    tv[7] = '{2, 12'h3C5, 3'd0, 12'h0E7, 12'h300, 104, 1, 8'hE7, 4'b1110};

    repeat (3) @(negedge clk);
    chk("rst cs0", 32'(cs0), 32'h1);
    chk("rst cs2", 32'(cs2), 32'hF);
    chk("rst sclk0", 32'(sclk0), 32'h0);
    chk("rst sclk1", 32'(sclk1), 32'h1);
    chk("rst mosi", 32'({mosi0, mosi1, mosi2}), 32'h0);
    chk("rst rvld", 32'({rv0, rv1, rv2}), 32'h0);
    chk("rst rdata", 32'({rd0, rd1, rd2}), 32'h0);
    chk("rst rdy", 32'({rdy0, rdy1, rdy2}), 32'h7);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(tv[i].d, tv[i].cmd, tv[i].sel, tv[i].rsp, lat, low_n, rv_n, pat);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'd108);
      chk($sformatf("v%0d cs low cycles", i), 32'(low_n), 32'(tv[i].cs_low));
      chk($sformatf("v%0d cs pattern", i), 32'(pat), 32'(tv[i].pat));
      chk($sformatf("v%0d mosi", i), 32'(cap), 32'(tv[i].mosi));
      chk($sformatf("v%0d rvld pulses", i), 32'(rv_n), 32'(tv[i].rv));
      chk($sformatf("v%0d rdata", i), 32'(rd_m), 32'(tv[i].rdata));
    end

    // Back-to-back on u0: cmd_vld held, cmd_in swapped while busy.
    cur = 0; resp = 12'h05A; clr_cnt++;
    @(negedge clk);
    cmd_in = 12'h8FF; vld[0] = 1'b1;
    phase = 0; k = 0; rdy_k = 0; cs_hi = 0; end_k = 0; rv_n = 0;
    cap1 = '0; rdy_after = 1'b1; prev_low = 1'b0;
    while (phase < 3 && k < 600) begin
      @(negedge clk);
      k++;
      if (k == 1) cmd_in = 12'h0AA;
      if (rv_m) rv_n++;
      case (phase)
        0: if (prev_low && !cs_low_m) begin cap1 = cap; phase = 1; cs_hi = 1; end
        1: begin
             if (rdy_k != 0 && k == rdy_k + 1) rdy_after = rdy_m;
             if (rdy_m && rdy_k == 0) rdy_k = k;
             if (cs_low_m) begin phase = 2; vld[0] = 1'b0; end
             else cs_hi++;
           end
        default: if (rdy_m) begin end_k = k; phase = 3; end
      endcase
      prev_low = cs_low_m;
    end
    chk("b2b timeout", 32'(phase), 32'd3);
    chk("b2b first idle", 32'(rdy_k), 32'd109);
    chk("b2b immediate accept", 32'(rdy_after), 32'd0);
    // GAP of 4 cycles plus the single IDLE cycle that accepts the next command.
    chk("b2b cs high cycles", 32'(cs_hi), 32'd5);
    chk("b2b first mosi", 32'(cap1), 32'h8FF);
    chk("b2b second latency", 32'(end_k - rdy_k), 32'd109);
    chk("b2b second mosi", 32'(cap), 32'h000);
    chk("b2b rvld pulses", 32'(rv_n), 32'd1);
    chk("b2b rdata", 32'(rd0), 32'h5A);
    rv_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (!rdy_m || cs_low_m) rv_n++;
    end
    chk("b2b nothing queued", 32'(rv_n), 32'd0);

    // Reset during SHIFT of a u0 read.
    cur = 0; resp = 12'h096; rv_n = 0;
    @(negedge clk);
    cmd_in = 12'h300; vld[0] = 1'b1;
    @(negedge clk);
    vld[0] = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rv0) rv_n++;
    end
    rst_n = 1'b0;
    #1;
    chk("abort cs", 32'(cs0), 32'h1);
    chk("abort sclk", 32'(sclk0), 32'h0);
    chk("abort mosi", 32'(mosi0), 32'h0);
    chk("abort rdy", 32'(rdy0), 32'h1);
    chk("abort rdata", 32'(rd0), 32'h0);
    repeat (3) begin
      @(negedge clk);
      if (rv0) rv_n++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rv0) rv_n++;
    end
    chk("abort no rvld", 32'(rv_n), 32'd0);
    run_txn(0, 12'h300, 3'd0, 12'h096, lat, low_n, rv_n, pat);
    chk("post-reset latency", 32'(lat), 32'd108);
    chk("post-reset rvld", 32'(rv_n), 32'd1);
    chk("post-reset rdata", 32'(rd0), 32'h96);
    chk("post-reset mosi", 32'(cap), 32'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
